// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit: PC owner, single-outstanding imem handshake, instruction     |
// | register feeding control. Optional watchdog: FETCH_TIMEOUT_EN.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter int ADDR_WIDTH           = 16,
  parameter int INST_WIDTH           = 16,
  parameter int OP_CODE_WIDTH        = 4,
  parameter int FUNCTION_CODE_WIDTH  = 4,
  parameter int BRANCH_CONTROL_WIDTH = 2,
  parameter int PC_STEP              = 2,
  parameter int RESET_PC             = 0,
  parameter int TIMEOUT_CYCLES       = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            imem_req,
  output logic [ADDR_WIDTH-1:0]           imem_addr,
  input  logic                            imem_ack,
  input  logic [INST_WIDTH-1:0]           imem_rdata,
  input  logic                            imem_err,
  output logic                            inst_valid,
  output logic [INST_WIDTH-1:0]           inst,
  output logic [OP_CODE_WIDTH-1:0]        op_code,
  output logic [FUNCTION_CODE_WIDTH-1:0]  func_code,
  output logic [ADDR_WIDTH-1:0]           inst_pc,
  input  logic                            inst_ready,
  input  logic                            jump,
  input  logic [ADDR_WIDTH-1:0]           jump_target,
  input  logic [BRANCH_CONTROL_WIDTH-1:0] branch_control,
  input  logic                            cmp_eq,
  input  logic                            cmp_gt,
  input  logic                            cmp_lt,
  input  logic [ADDR_WIDTH-1:0]           branch_offset,
  input  logic                            halt,
  output logic                            exc_inst_memory,
  output logic                            halted
);

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] STEP   = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);

  localparam logic [BRANCH_CONTROL_WIDTH-1:0] BC_EQ = BRANCH_CONTROL_WIDTH'(1);
  localparam logic [BRANCH_CONTROL_WIDTH-1:0] BC_GT = BRANCH_CONTROL_WIDTH'(2);
  localparam logic [BRANCH_CONTROL_WIDTH-1:0] BC_LT = BRANCH_CONTROL_WIDTH'(3);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0]   inst_q, inst_d;
  logic [ADDR_WIDTH-1:0]   inst_pc_q, inst_pc_d;
  logic                    inst_valid_q, inst_valid_d;
  logic                    exc_q, exc_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  logic                  pc_aligned;
  logic                  req;
  logic                  xfer;
  logic                  br_taken;
  logic [ADDR_WIDTH-1:0] seq_pc;
  logic [ADDR_WIDTH-1:0] br_pc;

  // Request is masked during reset so a pending transfer is dropped immediately.
  assign pc_aligned = ((pc_q % STEP) == '0);
  assign req        = (state_q == ST_REQ) && pc_aligned && !rst;
  assign xfer       = req && imem_ack;

  assign seq_pc   = inst_pc_q + STEP;
  assign br_pc    = seq_pc + branch_offset;
  assign br_taken = ((branch_control == BC_EQ) && cmp_eq) ||
                    ((branch_control == BC_GT) && cmp_gt) ||
                    ((branch_control == BC_LT) && cmp_lt);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    exc_d        = exc_q;
`ifdef FETCH_TIMEOUT_EN
    tmo_d        = '0;
`endif
    case (state_q)
      ST_REQ: begin
        if (!pc_aligned) begin
          exc_d        = 1'b1;
          inst_valid_d = 1'b0;
          state_d      = ST_HALTED;
        end else if (xfer) begin
          if (imem_err) begin
            exc_d        = 1'b1;
            inst_valid_d = 1'b0;
            state_d      = ST_HALTED;
          end else begin
            inst_d       = imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            state_d      = ST_HOLD;
          end
`ifdef FETCH_TIMEOUT_EN
        end else if (tmo_q == TMO_LAST) begin
          exc_d        = 1'b1;
          inst_valid_d = 1'b0;
          state_d      = ST_HALTED;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
`endif
        end
      end
      ST_HOLD: begin
        if (inst_ready) begin
          inst_valid_d = 1'b0;
          // Halt outranks jump and leaves pc at the halting instruction.
          if (halt) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_REQ;
            if (jump) begin
              pc_d = jump_target;
            end else if (br_taken) begin
              pc_d = br_pc;
            end else begin
              pc_d = seq_pc;
            end
          end
        end
      end
      ST_HALTED: begin
        inst_valid_d = 1'b0;
      end
      default: begin
        inst_valid_d = 1'b0;
        state_d      = ST_HALTED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_REQ;
      pc_q         <= RST_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      exc_q        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      exc_q        <= exc_d;
`ifdef FETCH_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign imem_req        = req;
  assign imem_addr       = pc_q;
  assign inst_valid      = inst_valid_q;
  assign inst            = inst_q;
  assign op_code         = inst_q[INST_WIDTH-1 -: OP_CODE_WIDTH];
  assign func_code       = inst_q[FUNCTION_CODE_WIDTH-1:0];
  assign inst_pc         = inst_pc_q;
  assign exc_inst_memory = exc_q;
  assign halted          = (state_q == ST_HALTED);

endmodule
`default_nettype wire
